// File: rtl/uart_tx_frame_pkg.sv
// Shared UART definitions: frame FSM encoding and line-level constants,
// used by both the TX frame serializer and the RX deserializer.
package uart_tx_frame_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam logic PAR_EVEN  = 1'b0;
   localparam logic PAR_ODD   = 1'b1;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit edge counter: counts 0..prescale-1 while running and pulses
// bit_done_o on the last cycle of each bit period.
module uart_tx_bit_timer #(
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      run_i,
   input  logic [PRESCALE_WIDTH-1:0] prescale_i,
   output logic                      bit_done_o
);

   logic [PRESCALE_WIDTH-1:0] cnt_q;
   logic                      last_w;

   // prescale_i is the latched, non-zero copy, so the subtraction cannot wrap.
   assign last_w     = (cnt_q == (prescale_i - 1'b1));
   assign bit_done_o = run_i & last_w;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt_q <= '0;
      end else if (!run_i || last_w) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: serializes start, data LSB first, optional parity and
// one stop bit, each held for the latched prescale count of CLK cycles.
module uart_tx_frame
   import uart_tx_frame_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [DATA_WIDTH-1:0]     P_DATA,
   input  logic                      DATA_VALID,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic                      TX_OUT,
   output logic                      busy,
   output uart_state_e               state_o
);

   localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

   uart_state_e               state_q;
   logic [DATA_WIDTH-1:0]     data_q;
   logic                      par_en_q;
   logic                      par_bit_q;
   logic [PRESCALE_WIDTH-1:0] presc_q;
   logic [BIT_CNT_W-1:0]      bit_cnt_q;
   logic [BIT_CNT_W-1:0]      bit_cnt_d;
   logic                      tx_q;
   logic                      busy_q;
   logic                      bit_done;

   assign bit_cnt_d = bit_cnt_q + 1'b1;

   uart_tx_bit_timer #(
      .PRESCALE_WIDTH (PRESCALE_WIDTH)
   ) u_bit_timer (
      .CLK        (CLK),
      .RST        (RST),
      .run_i      (busy_q),
      .prescale_i (presc_q),
      .bit_done_o (bit_done)
   );

   // Outputs come straight from flops so the pad never sees decode glitches.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= ST_IDLE;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         presc_q   <= PRESCALE_WIDTH'(1);
         bit_cnt_q <= '0;
         tx_q      <= STOP_BIT;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               tx_q   <= STOP_BIT;
               busy_q <= 1'b0;
               if (DATA_VALID) begin
                  data_q    <= P_DATA;
                  par_en_q  <= PAR_EN;
                  par_bit_q <= (PAR_TYP == PAR_ODD) ? ~^P_DATA : ^P_DATA;
                  presc_q   <= (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
                  bit_cnt_q <= '0;
                  tx_q      <= START_BIT;
                  busy_q    <= 1'b1;
                  state_q   <= ST_START;
               end
            end
            ST_START: begin
               if (bit_done) begin
                  tx_q    <= data_q[0];
                  state_q <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_done) begin
                  if (bit_cnt_q == LAST_BIT) begin
                     if (par_en_q) begin
                        tx_q    <= par_bit_q;
                        state_q <= ST_PARITY;
                     end else begin
                        tx_q    <= STOP_BIT;
                        state_q <= ST_STOP;
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_d;
                     tx_q      <= data_q[bit_cnt_d];
                  end
               end
            end
            ST_PARITY: begin
               if (bit_done) begin
                  tx_q    <= STOP_BIT;
                  state_q <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (bit_done) begin
                  tx_q    <= STOP_BIT;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               tx_q    <= STOP_BIT;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign TX_OUT  = tx_q;
   assign busy    = busy_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: directed frames plus randomized loopback frames,
// each checked against an expected bit sequence and a mid-bit sampling receiver.
module tb_uart_tx_frame;
   import uart_tx_frame_pkg::*;

   localparam int DW    = 8;
   localparam int PW    = 6;
   localparam int LIMIT = 400;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic [DW-1:0] P_DATA = '0;
   logic          DATA_VALID = 1'b0;
   logic          PAR_EN = 1'b0;
   logic          PAR_TYP = 1'b0;
   logic [PW-1:0] prescale = 6'd8;
   logic          TX_OUT;
   logic          busy;
   uart_state_e   state_o;

   int tests_run    = 0;
   int tests_failed = 0;

   logic          tx_log[$];
   logic          busy_log[$];
   logic [DW-1:0] exp_q[$];

   always #5 CLK = ~CLK;

   uart_tx_frame #(
      .DATA_WIDTH     (DW),
      .PRESCALE_WIDTH (PW)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .prescale   (prescale),
      .TX_OUT     (TX_OUT),
      .busy       (busy),
      .state_o    (state_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Parity bit that makes the total count of ones even (typ=0) or odd (typ=1).
   function automatic logic exp_parity(input logic [DW-1:0] d, input logic typ);
      int ones;
      ones = 0;
      for (int i = 0; i < DW; i++) ones += int'(d[i]);
      if (typ) return ((ones % 2) == 0);
      return ((ones % 2) == 1);
   endfunction

   task automatic log_cycle();
      tx_log.push_back(TX_OUT);
      busy_log.push_back(busy);
   endtask

   task automatic check_frame(input int s, input logic [DW-1:0] d, input logic pe,
                              input logic pt, input int p, input string tag);
      logic          exp_bits[$];
      int            nb;
      int            bad;
      int            bad_idx;
      int            busy_len;
      int            idx;
      logic [DW-1:0] rx_word;
      logic          rx_err;
      logic [DW-1:0] want;
      exp_bits.push_back(1'b0);
      for (int i = 0; i < DW; i++) exp_bits.push_back(d[i]);
      if (pe) exp_bits.push_back(exp_parity(d, pt));
      exp_bits.push_back(1'b1);
      nb = exp_bits.size();
      want = exp_q.pop_front();

      chk({tag, " log_complete"}, 32'(tx_log.size() >= s + nb * p + 1), 32'd1);
      if (tx_log.size() < s + nb * p + 1) return;

      bad = 0;
      bad_idx = -1;
      for (int b = 0; b < nb; b++) begin
         for (int c = 0; c < p; c++) begin
            idx = s + b * p + c;
            if (tx_log[idx] !== exp_bits[b] || busy_log[idx] !== 1'b1) begin
               if (bad == 0) bad_idx = idx - s;
               bad++;
            end
         end
      end
      chk($sformatf("%s wave_bad_cycles(first@%0d)", tag, bad_idx), 32'(bad), 32'd0);

      busy_len = 0;
      while (s + busy_len < busy_log.size() && busy_log[s + busy_len] === 1'b1) busy_len++;
      chk({tag, " busy_len"}, 32'(busy_len), 32'(nb * p));
      chk({tag, " idle_tx"}, 32'(tx_log[s + nb * p]), 32'd1);
      chk({tag, " idle_busy"}, 32'(busy_log[s + nb * p]), 32'd0);

      // Receiver view: sample each bit in the middle of its period.
      rx_err = (tx_log[s + p / 2] !== 1'b0);
      for (int i = 0; i < DW; i++) rx_word[i] = tx_log[s + (1 + i) * p + p / 2];
      if (pe) rx_err |= (tx_log[s + (1 + DW) * p + p / 2] !== ((^rx_word) ^ pt));
      rx_err |= (tx_log[s + (nb - 1) * p + p / 2] !== 1'b1);
      chk({tag, " rx_frame_err"}, 32'(rx_err), 32'd0);
      chk({tag, " rx_word"}, 32'(rx_word), 32'(want));
   endtask

   task automatic run_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                            input logic [PW-1:0] presc, input string tag);
      int k;
      int p_eff;
      tx_log.delete();
      busy_log.delete();
      @(negedge CLK);
      P_DATA = d;
      PAR_EN = pe;
      PAR_TYP = pt;
      prescale = presc;
      DATA_VALID = 1'b1;
      exp_q.push_back(d);
      @(negedge CLK);
      DATA_VALID = 1'b0;
      P_DATA = DW'($urandom);
      PAR_EN = 1'($urandom);
      PAR_TYP = 1'($urandom);
      prescale = PW'($urandom);
      log_cycle();
      k = 1;
      while (busy_log[$] === 1'b1 && k < LIMIT) begin
         @(negedge CLK);
         log_cycle();
         k++;
      end
      p_eff = (presc == '0) ? 1 : int'(presc);
      check_frame(0, d, pe, pt, p_eff, tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DW-1:0] rd;
      logic          rpe;
      logic          rpt;
      logic [PW-1:0] rp;

      // Reset held with a request present: line must stay idle.
      RST = 1'b0;
      DATA_VALID = 1'b1;
      P_DATA = 8'h55;
      repeat (3) @(negedge CLK);
      chk("reset tx", 32'(TX_OUT), 32'd1);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset state", 32'(state_o), 32'(ST_IDLE));
      DATA_VALID = 1'b0;
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      chk("post_reset tx", 32'(TX_OUT), 32'd1);
      chk("post_reset busy", 32'(busy), 32'd0);

      run_frame(8'hA5, 1'b0, 1'b0, 6'd8, "t1_a5_p8");
      run_frame(8'h01, 1'b1, 1'b0, 6'd8, "t2_even_p8");
      run_frame(8'h01, 1'b1, 1'b1, 6'd16, "t3_odd_p16");
      run_frame(8'h96, 1'b1, 1'b1, 6'd0, "presc0");

      // DATA_VALID held high across two frames; P_DATA changes mid-frame.
      tx_log.delete();
      busy_log.delete();
      @(negedge CLK);
      P_DATA = 8'h3C;
      PAR_EN = 1'b0;
      PAR_TYP = 1'b0;
      prescale = 6'd8;
      DATA_VALID = 1'b1;
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'hC3);
      for (int k = 0; k < 170; k++) begin
         @(negedge CLK);
         log_cycle();
         if (k == 10) P_DATA = 8'hC3;
         if (k == 100) DATA_VALID = 1'b0;
      end
      check_frame(0, 8'h3C, 1'b0, 1'b0, 8, "t4_first");
      check_frame(81, 8'hC3, 1'b0, 1'b0, 8, "t4_second");

      // Asynchronous reset in the middle of data bit 3 (a zero bit of 0xA5).
      @(negedge CLK);
      P_DATA = 8'hA5;
      PAR_EN = 1'b0;
      prescale = 6'd8;
      DATA_VALID = 1'b1;
      @(negedge CLK);
      DATA_VALID = 1'b0;
      repeat (35) @(negedge CLK);
      chk("t5 pre_rst tx", 32'(TX_OUT), 32'd0);
      chk("t5 pre_rst busy", 32'(busy), 32'd1);
      RST = 1'b0;
      #1;
      chk("t5 async tx", 32'(TX_OUT), 32'd1);
      chk("t5 async busy", 32'(busy), 32'd0);
      chk("t5 async state", 32'(state_o), 32'(ST_IDLE));
      @(negedge CLK);
      RST = 1'b1;
      run_frame(8'hFF, 1'b0, 1'b0, 6'd8, "t5_after_rst");

      // Loopback with random words, parity modes and legal prescales.
      for (int n = 0; n < 10; n++) begin
         rd  = DW'($urandom);
         rpe = 1'($urandom);
         rpt = 1'($urandom);
         case ($urandom_range(0, 2))
            0:       rp = 6'd8;
            1:       rp = 6'd16;
            default: rp = 6'd32;
         endcase
         run_frame(rd, rpe, rpt, rp, $sformatf("rand%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
